// File: rtl/paddle_controller.sv
// Paddle AI: per frame tick, picks a target Y (hold, track the ball, or predict the
// ball's intercept with the paddle column including wall bounces), then moves the
// paddle one bounded step toward it, clamped to the playfield.
module paddle_controller #(
  parameter int COORD_W     = 16,
  parameter int HALF_PADDLE = 50,
  parameter int STEP        = 5,
  parameter int DEAD_ZONE   = 2,
  parameter int MAX_ITER    = 64,
  parameter int INIT_Y      = 190
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic [1:0]           mode,
  input  logic [2*COORD_W-1:0] dimensions,
  input  logic [2*COORD_W-1:0] ball_pos,
  input  logic [2*COORD_W-1:0] ball_vel,
  input  logic [COORD_W-1:0]   paddle_x,
  output logic [COORD_W-1:0]   paddle_y,
  output logic                 busy,
  output logic                 done,
  output logic                 at_limit,
  output logic                 tick_overrun
);

  localparam int IW = COORD_W + 2;
  localparam int CW = $clog2(MAX_ITER + 1);

  typedef logic signed [IW-1:0] sword_t;
  typedef enum logic [1:0] {IDLE, PREDICT, MOVE} state_t;

  localparam sword_t ZERO     = sword_t'(0);
  localparam sword_t ONE      = sword_t'(1);
  localparam sword_t HALF_S   = sword_t'(HALF_PADDLE);
  localparam sword_t PADDLE_H = sword_t'(2 * HALF_PADDLE);
  localparam sword_t STEP_S   = sword_t'(STEP);
  localparam sword_t DEAD_S   = sword_t'(DEAD_ZONE);
  localparam sword_t SAT_HI   = sword_t'((1 << COORD_W) - 1);
  localparam sword_t SAT_LO   = ZERO - SAT_HI - ONE;

  function automatic sword_t clamp(input sword_t v, input sword_t lo, input sword_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Keeps the predicted y inside a range where the next y+vy cannot wrap.
  function automatic sword_t sat_coord(input sword_t v);
    return clamp(v, SAT_LO, SAT_HI);
  endfunction

  function automatic sword_t uext(input logic [COORD_W-1:0] v);
    return sword_t'({2'b00, v});
  endfunction

  function automatic sword_t sext(input logic [COORD_W-1:0] v);
    return sword_t'({{2{v[COORD_W-1]}}, v});
  endfunction

  state_t        state, state_nx;
  logic [CW-1:0] iter, iter_nx;
  sword_t        h, px, x, y, vx, vy, target;
  sword_t        x_nx, y_nx, vy_nx, target_nx;
  sword_t        x_step, y_sum, y_refl, vy_refl;
  sword_t        centre, cand, limit, moved;
  logic          crossed, away, load;
  logic [COORD_W-1:0] py_nx;
  logic          done_nx, lim_nx, overrun_nx;
  logic          unused_width;

  assign unused_width = ^dimensions[2*COORD_W-1:COORD_W];
  assign busy = (state != IDLE);

  // Next-state, prediction step and paddle move arithmetic.
  always_comb begin
    state_nx   = state;
    iter_nx    = iter;
    x_nx       = x;
    y_nx       = y;
    vy_nx      = vy;
    target_nx  = target;
    load       = 1'b0;
    py_nx      = paddle_y;
    done_nx    = 1'b0;
    lim_nx     = at_limit;
    overrun_nx = frame_tick && (state != IDLE);

    x_step  = x + vx;
    y_sum   = y + vy;
    y_refl  = y_sum;
    vy_refl = vy;
    if (y_sum < ZERO) begin
      y_refl  = sat_coord(ZERO - y_sum);
      vy_refl = ZERO - vy;
    end else if (y_sum >= h) begin
      y_refl  = sat_coord(((h - ONE) <<< 1) - y_sum);
      vy_refl = ZERO - vy;
    end
    crossed = (vx > ZERO) ? (x_step >= px) : (x_step <= px);
    away    = (vx == ZERO) || ((vx > ZERO) && (x > px)) || ((vx < ZERO) && (x < px));

    centre = uext(paddle_y) + HALF_S;
    if (centre < target - DEAD_S)      cand = uext(paddle_y) + STEP_S;
    else if (centre > target + DEAD_S) cand = uext(paddle_y) - STEP_S;
    else                               cand = uext(paddle_y);
    limit = h - PADDLE_H;
    moved = (limit < ZERO) ? ZERO : clamp(cand, ZERO, limit);

    case (state)
      IDLE: begin
        if (frame_tick) begin
          load     = 1'b1;
          state_nx = (mode == 2'd2) ? PREDICT : MOVE;
        end
      end
      PREDICT: begin
        if (away) begin
          target_nx = h >>> 1;
          state_nx  = MOVE;
        end else begin
          x_nx    = x_step;
          y_nx    = y_refl;
          vy_nx   = vy_refl;
          iter_nx = iter + CW'(1);
          if (crossed || (iter == CW'(MAX_ITER - 1))) begin
            target_nx = clamp(y_refl, ZERO, h - ONE);
            state_nx  = MOVE;
          end
        end
      end
      MOVE: begin
        py_nx    = moved[COORD_W-1:0];
        lim_nx   = (moved == ZERO) || (moved == limit);
        done_nx  = 1'b1;
        iter_nx  = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control state and outputs, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      iter         <= '0;
      paddle_y     <= COORD_W'(INIT_Y);
      done         <= 1'b0;
      at_limit     <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      state        <= state_nx;
      iter         <= iter_nx;
      paddle_y     <= py_nx;
      done         <= done_nx;
      at_limit     <= lim_nx;
      tick_overrun <= overrun_nx;
    end
  end

  // Datapath registers: inputs captured on the accepted tick, then stepped by PREDICT.
  always_ff @(posedge clk) begin
    if (load) begin
      h      <= uext(dimensions[COORD_W-1:0]);
      px     <= uext(paddle_x);
      x      <= uext(ball_pos[2*COORD_W-1:COORD_W]);
      y      <= uext(ball_pos[COORD_W-1:0]);
      vx     <= sext(ball_vel[2*COORD_W-1:COORD_W]);
      vy     <= sext(ball_vel[COORD_W-1:0]);
      target <= (mode == 2'd1) ? uext(ball_pos[COORD_W-1:0]) : uext(paddle_y) + HALF_S;
    end else begin
      x      <= x_nx;
      y      <= y_nx;
      vy     <= vy_nx;
      target <= target_nx;
    end
  end

endmodule
